// File: rtl/pc_fetch_ctrl_if.sv
// Fetch-stage next-PC interface: redirect inputs
// from hazard/D-stage/CP0 and the inst SRAM request.
interface pc_fetch_ctrl_if #(
   parameter int WIDTH = 32
);
   logic             stall_f;
   logic             branch_d;
   logic [WIDTH-1:0] branch_tgt_d;
   logic             flush_exc;
   logic [WIDTH-1:0] exc_pc;
   logic [WIDTH-1:0] pc_f;
   logic             inst_req;
   logic             adel_f;
   logic             redir_pending;

   modport master (
      input  stall_f,
      input  branch_d,
      input  branch_tgt_d,
      input  flush_exc,
      input  exc_pc,
      output pc_f,
      output inst_req,
      output adel_f,
      output redir_pending
   );

   modport slave (
      output stall_f,
      output branch_d,
      output branch_tgt_d,
      output flush_exc,
      output exc_pc,
      input  pc_f,
      input  inst_req,
      input  adel_f,
      input  redir_pending
   );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// Next-PC sequencer: owns the fetch PC, buffers
// branches that resolve while IF is stalled.
module pc_fetch_ctrl #(
   parameter int               WIDTH    = 32,
   parameter logic [WIDTH-1:0] RESET_PC = 32'hBFC0_0000,
   parameter int               STEP     = 4
) (
   input logic           clk,
   input logic           rst,
   pc_fetch_ctrl_if.master bus
);
   typedef enum logic [1:0] {
      BOOT = 2'd0,
      RUN  = 2'd1,
      PEND = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] pc_q, pc_d;
   logic [WIDTH-1:0] pend_tgt_q, pend_tgt_d;
   logic             inst_req_q, inst_req_d;
   logic             redir_q, redir_d;

   // Next-PC arbitration; flush beats stall beats branch.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      pend_tgt_d = pend_tgt_q;
      unique case (state_q)
         BOOT: begin
            state_d = RUN;
         end
         RUN: begin
            if (bus.flush_exc) begin
               pc_d = bus.exc_pc;
            end else if (bus.stall_f && bus.branch_d) begin
               pend_tgt_d = bus.branch_tgt_d;
               state_d    = PEND;
            end else if (bus.stall_f) begin
               pc_d = pc_q;
            end else if (bus.branch_d) begin
               pc_d = bus.branch_tgt_d;
            end else begin
               pc_d = pc_q + WIDTH'(STEP);
            end
         end
         PEND: begin
            if (bus.flush_exc) begin
               pc_d       = bus.exc_pc;
               pend_tgt_d = '0;
               state_d    = RUN;
            end else if (bus.stall_f && bus.branch_d) begin
               pend_tgt_d = bus.branch_tgt_d;
            end else if (bus.stall_f) begin
               pc_d = pc_q;
            end else begin
               pc_d    = pend_tgt_q;
               state_d = RUN;
            end
         end
         default: begin
            state_d = BOOT;
            pc_d    = RESET_PC;
         end
      endcase
      inst_req_d = (state_d != BOOT);
      redir_d    = (state_d == PEND);
   end

   // State, PC and registered request outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= BOOT;
         pc_q       <= RESET_PC;
         pend_tgt_q <= '0;
         inst_req_q <= 1'b0;
         redir_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         pc_q       <= pc_d;
         pend_tgt_q <= pend_tgt_d;
         inst_req_q <= inst_req_d;
         redir_q    <= redir_d;
      end
   end

   assign bus.pc_f          = pc_q;
   assign bus.inst_req      = inst_req_q;
   assign bus.redir_pending = redir_q;
   assign bus.adel_f        = inst_req_q & (pc_q[1:0] != 2'b00);
endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Bench for pc_fetch_ctrl: behavioural next-PC
// model feeding a scoreboard, plus scenario checks.
module tb_pc_fetch_ctrl;
   localparam logic [31:0] RST_PC = 32'hBFC0_0000;

   typedef struct packed {
      logic [31:0] pc;
      logic        req;
      logic        redir;
      logic        adel;
   } exp_t;

   logic clk;
   logic rst;
   int   n_vec;
   int   n_bad;
   exp_t sb_q[$];

   int          m_st;
   logic [31:0] m_pc;
   logic [31:0] m_pend;

   pc_fetch_ctrl_if #(.WIDTH(32)) bus ();

   pc_fetch_ctrl #(
      .WIDTH(32),
      .RESET_PC(32'hBFC0_0000),
      .STEP(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [31:0] obs,
                      input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h",
                  tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_st   = 0;
      m_pc   = RST_PC;
      m_pend = 32'h0;
   endtask

   task automatic step(input logic st,
                       input logic br,
                       input logic [31:0] tgt,
                       input logic fl,
                       input logic [31:0] epc);
      exp_t e;
      bus.stall_f      = st;
      bus.branch_d     = br;
      bus.branch_tgt_d = tgt;
      bus.flush_exc    = fl;
      bus.exc_pc       = epc;
      if (m_st == 0) begin
         m_st = 1;
      end else if (fl) begin
         m_pc = epc;
         if (m_st == 2) m_pend = 32'h0;
         m_st = 1;
      end else if (st) begin
         if (br) begin
            m_pend = tgt;
            m_st   = 2;
         end
      end else if (m_st == 2) begin
         m_pc = m_pend;
         m_st = 1;
      end else if (br) begin
         m_pc = tgt;
      end else begin
         m_pc = m_pc + 32'd4;
      end
      e.pc    = m_pc;
      e.req   = (m_st != 0);
      e.redir = (m_st == 2);
      e.adel  = e.req && (m_pc[1:0] != 2'b00);
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      e = sb_q.pop_front();
      chk("sb_pc", bus.pc_f, e.pc);
      chk("sb_req", 32'(bus.inst_req), 32'(e.req));
      chk("sb_redir", 32'(bus.redir_pending),
          32'(e.redir));
      chk("sb_adel", 32'(bus.adel_f), 32'(e.adel));
   endtask

   task automatic idle();
      step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_pc"}, bus.pc_f, RST_PC);
      chk({tag, "_req"}, 32'(bus.inst_req), 32'h0);
      chk({tag, "_redir"}, 32'(bus.redir_pending), 32'h0);
      chk({tag, "_adel"}, 32'(bus.adel_f), 32'h0);
   endtask

   initial begin
      n_vec = 0;
      n_bad = 0;
      rst = 1'b1;
      bus.stall_f      = 1'b0;
      bus.branch_d     = 1'b0;
      bus.branch_tgt_d = 32'h0;
      bus.flush_exc    = 1'b0;
      bus.exc_pc       = 32'h0;
      model_reset();
      #12;
      chk_reset("rst");
      rst = 1'b0;

      // boot cycle ignores a flush
      step(1'b0, 1'b0, 32'h0, 1'b1, 32'h1234_5678);
      chk("s1_boot", bus.pc_f, 32'hBFC0_0000);
      idle();
      chk("s1_seq1", bus.pc_f, 32'hBFC0_0004);
      idle();
      idle();
      idle();
      chk("s1_seq4", bus.pc_f, 32'hBFC0_0010);

      step(1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'h0);
      chk("s2_br", bus.pc_f, 32'hBFC0_0100);
      idle();
      chk("s2_after", bus.pc_f, 32'hBFC0_0104);

      step(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'h0);
      chk("s3_hold", bus.pc_f, 32'hBFC0_0104);
      chk("s3_pend", 32'(bus.redir_pending), 32'h1);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      step(1'b0, 1'b1, 32'hDEAD_BEE0, 1'b0, 32'h0);
      chk("s3_rel", bus.pc_f, 32'hBFC0_0200);
      chk("s3_clr", 32'(bus.redir_pending), 32'h0);
      idle();

      // newest buffered branch wins
      step(1'b1, 1'b1, 32'hBFC0_0300, 1'b0, 32'h0);
      step(1'b1, 1'b1, 32'hBFC0_0400, 1'b0, 32'h0);
      idle();
      chk("s3_newest", bus.pc_f, 32'hBFC0_0400);

      step(1'b1, 1'b1, 32'hBFC0_0200, 1'b0, 32'h0);
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'hBFC0_0380);
      chk("s4_exc", bus.pc_f, 32'hBFC0_0380);
      chk("s4_clr", 32'(bus.redir_pending), 32'h0);
      idle();
      chk("s4_next", bus.pc_f, 32'hBFC0_0384);

      // flush overrides stall in RUN
      step(1'b1, 1'b0, 32'h0, 1'b1, 32'h8000_0180);
      chk("s4_runexc", bus.pc_f, 32'h8000_0180);

      step(1'b0, 1'b1, 32'hBFC0_0102, 1'b0, 32'h0);
      chk("s5_mis", bus.pc_f, 32'hBFC0_0102);
      chk("s5_adel", 32'(bus.adel_f), 32'h1);
      chk("s5_req", 32'(bus.inst_req), 32'h1);
      step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      idle();
      chk("s5_wrap", bus.pc_f, 32'h0000_0000);

      for (int i = 0; i < 40; i++) begin
         step(1'($urandom_range(0, 2) == 0),
              1'($urandom_range(0, 2) == 0),
              {$urandom_range(0, 65535), 14'h0, 2'(i)},
              1'($urandom_range(0, 9) == 0),
              {16'hBFC0, 16'($urandom_range(0, 65535))});
      end

      step(1'b1, 1'b1, 32'hBFC0_0600, 1'b0, 32'h0);
      chk("s6_inpend", 32'(bus.redir_pending), 32'h1);
      #2;
      rst = 1'b1;
      #1;
      chk_reset("s6_rst");
      model_reset();
      sb_q.delete();
      #1;
      rst = 1'b0;
      bus.stall_f  = 1'b0;
      bus.branch_d = 1'b0;
      idle();
      chk("s6_boot", bus.pc_f, 32'hBFC0_0000);
      idle();
      chk("s6_seq1", bus.pc_f, 32'hBFC0_0004);
      idle();
      chk("s6_seq2", bus.pc_f, 32'hBFC0_0008);

      $display("== %0d vectors applied, %0d miscompares ==",
               n_vec, n_bad);
      $finish;
   end
endmodule
